// File: rtl/pwm_capture.sv
// ---------------------------------------------------------------------------
// pwm_capture
//
// Measures the duty of an incoming motor PWM waveform. A measurement window
// lasts exactly PERIOD = 2**RPM_W clocks. During the window the block counts
// how many samples of the (optionally synchronised) input were high. It then
// publishes that count as an RPM code and pulses meas_valid for one cycle.
// The RPM code has the same width as the generator's mot_rpm input.
//
// Parameters:
//   RPM_W       - width of the RPM code; the window is 2**RPM_W clocks.
//   SYNC_STAGES - flops on mot_pwm before counting (0..3, 0 = direct).
//   CONTINUOUS  - 1: a new window starts right after each window ends.
//
// Ports:
//   clk        in   system clock, all logic on posedge
//   reset      in   synchronous, active-high reset
//   start      in   single-cycle pulse that (re)starts a measurement window
//   mot_pwm    in   PWM waveform under measurement
//   rpm_meas   out  high-cycle count of the last completed window, saturated
//   meas_valid out  one-cycle strobe; rpm_meas and sat update with it
//   sat        out  last window was high for all PERIOD samples
//   busy       out  a window is in progress
//   state_dbg  out  current FSM state (IDLE=0, MEASURE=1, DONE=2)
//
// Handshake: start and meas_valid are plain single-cycle strobes with no
// ready/backpressure. A start is always accepted (except under reset), and
// the consumer must capture rpm_meas/sat on the cycle meas_valid is high;
// those outputs then hold until the next strobe.
// ---------------------------------------------------------------------------
module pwm_capture #(
    parameter int RPM_W       = 7,
    parameter int SYNC_STAGES = 0,
    parameter bit CONTINUOUS  = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             mot_pwm,
    output logic [RPM_W-1:0] rpm_meas,
    output logic             meas_valid,
    output logic             sat,
    output logic             busy,
    output logic [1:0]       state_dbg
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        MEASURE = 2'd1,
        DONE    = 2'd2
    } state_t;

    // Counters are one bit wider than the code so a full window (PERIOD)
    // is representable without wrapping.
    localparam logic [RPM_W:0]   PERIOD  = {1'b1, {RPM_W{1'b0}}};
    localparam logic [RPM_W:0]   ONE     = {{RPM_W{1'b0}}, 1'b1};
    localparam logic [RPM_W:0]   LAST    = PERIOD - ONE;
    localparam logic [RPM_W-1:0] RPM_MAX = {RPM_W{1'b1}};

    state_t           state;
    logic [RPM_W:0]   win_cnt;
    logic [RPM_W:0]   hi_cnt;
    logic             pwm_s;
    logic [RPM_W:0]   pwm_inc;

    // -----------------------------------------------------------------------
    // Input synchroniser: pwm_s is mot_pwm delayed by SYNC_STAGES clocks.
    // -----------------------------------------------------------------------
    generate
        if (SYNC_STAGES == 0) begin : g_no_sync
            assign pwm_s = mot_pwm;
        end else begin : g_sync
            logic [SYNC_STAGES-1:0] sync_q;

            always_ff @(posedge clk) begin
                if (reset) begin
                    sync_q <= '0;
                end else begin
                    sync_q[0] <= mot_pwm;
                    for (int i = 1; i < SYNC_STAGES; i++) begin
                        sync_q[i] <= sync_q[i-1];
                    end
                end
            end

            assign pwm_s = sync_q[SYNC_STAGES-1];
        end
    endgenerate

    assign pwm_inc   = {{RPM_W{1'b0}}, pwm_s};
    assign state_dbg = state;

    // -----------------------------------------------------------------------
    // Window FSM. All outputs are registered. busy mirrors "state is
    // MEASURE", so it is set on every transition into MEASURE and cleared on
    // every transition out of it.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            win_cnt    <= '0;
            hi_cnt     <= '0;
            rpm_meas   <= '0;
            meas_valid <= 1'b0;
            sat        <= 1'b0;
            busy       <= 1'b0;
        end else begin
            meas_valid <= 1'b0;

            case (state)
                IDLE: begin
                    busy <= 1'b0;
                    if (start) begin
                        state   <= MEASURE;
                        win_cnt <= '0;
                        hi_cnt  <= '0;
                        busy    <= 1'b1;
                    end
                end

                MEASURE: begin
                    if (start) begin
                        // Restart: the sample on this edge is discarded and
                        // the aborted window never produces a strobe.
                        win_cnt <= '0;
                        hi_cnt  <= '0;
                    end else begin
                        win_cnt <= win_cnt + ONE;
                        hi_cnt  <= hi_cnt + pwm_inc;
                        // This edge takes the PERIOD-th sample.
                        if (win_cnt == LAST) begin
                            state <= DONE;
                            busy  <= 1'b0;
                        end
                    end
                end

                DONE: begin
                    meas_valid <= 1'b1;
                    sat        <= (hi_cnt == PERIOD);
                    rpm_meas   <= (hi_cnt == PERIOD) ? RPM_MAX : hi_cnt[RPM_W-1:0];
                    // The DONE edge doubles as the start edge of the next
                    // window, so back-to-back windows have no gap.
                    if (CONTINUOUS || start) begin
                        state   <= MEASURE;
                        win_cnt <= '0;
                        hi_cnt  <= '0;
                        busy    <= 1'b1;
                    end else begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end

                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pwm_capture.sv
// ---------------------------------------------------------------------------
// tb_pwm_capture
//
// Bench for pwm_capture. Two instances share the clock and reset:
//   u_dut0 : RPM_W=7, SYNC_STAGES=0, CONTINUOUS=0 (single-shot windows)
//   u_dut1 : RPM_W=7, SYNC_STAGES=2, CONTINUOUS=1 (free-running windows)
// Inputs are driven 1 time unit after each rising edge; outputs are sampled
// at that same point, well away from the next active edge.
// ---------------------------------------------------------------------------
module tb_pwm_capture;

    localparam int RPM_W  = 7;
    localparam int PERIOD = 128;

    typedef struct {
        int         hi_len;   // number of leading high samples in the window
        logic [6:0] exp_rpm;
        logic       exp_sat;
    } vec_t;

    // clock / reset
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    // dut0 signals
    logic             start0, pwm0;
    logic [RPM_W-1:0] rpm0;
    logic             valid0, sat0, busy0;
    logic [1:0]       st0;

    // dut1 signals
    logic             start1, pwm1;
    logic [RPM_W-1:0] rpm1;
    logic             valid1, sat1, busy1;
    logic [1:0]       st1;

    pwm_capture #(.RPM_W(RPM_W), .SYNC_STAGES(0), .CONTINUOUS(1'b0)) u_dut0 (
        .clk(clk), .reset(reset), .start(start0), .mot_pwm(pwm0),
        .rpm_meas(rpm0), .meas_valid(valid0), .sat(sat0), .busy(busy0),
        .state_dbg(st0)
    );

    pwm_capture #(.RPM_W(RPM_W), .SYNC_STAGES(2), .CONTINUOUS(1'b1)) u_dut1 (
        .clk(clk), .reset(reset), .start(start1), .mot_pwm(pwm1),
        .rpm_meas(rpm1), .meas_valid(valid1), .sat(sat1), .busy(busy1),
        .state_dbg(st1)
    );

    // scoreboard counters
    int n_checks = 0;
    int n_pass   = 0;

    // free-running generator model for dut1: duty 100 of 128
    int gen_ph = 0;

    // window contents for dut0 (sample k is taken on edge T0+1+k)
    logic win_bits[PERIOD];

    vec_t vecs[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    // One clock: inputs already set, advance through the edge, settle.
    task automatic step();
        pwm1 = (gen_ph < 100);
        @(posedge clk);
        #1;
        gen_ph = (gen_ph + 1) % PERIOD;
    endtask

    // Reference model: a window's result is the number of high samples,
    // with a full window reported as the maximum code plus sat.
    function automatic int model_count();
        int c = 0;
        for (int k = 0; k < PERIOD; k++) c += int'(win_bits[k]);
        return c;
    endfunction

    // Run one complete single-shot window on dut0 using win_bits.
    task automatic run_window(input string name, input logic [6:0] exp_rpm, input logic exp_sat);
        int early;
        early  = 0;
        start0 = 1'b1;
        pwm0   = 1'($urandom_range(0, 1));
        step();
        start0 = 1'b0;
        check({name, "_busy_run"}, busy0, 1);
        for (int k = 0; k < PERIOD; k++) begin
            pwm0 = win_bits[k];
            step();
            if (valid0) early++;
        end
        pwm0 = 1'($urandom_range(0, 1));
        step();
        check({name, "_valid"}, valid0, 1);
        check({name, "_rpm"}, rpm0, exp_rpm);
        check({name, "_sat"}, sat0, exp_sat);
        check({name, "_busy_after"}, busy0, 0);
        check({name, "_no_early_strobe"}, early, 0);
        step();
        check({name, "_valid_one_cycle"}, valid0, 0);
    endtask

    initial begin
        int cnt, strobes, last_n, n_str1;

        vecs[0] = '{0,   7'd0,   1'b0};
        vecs[1] = '{37,  7'd37,  1'b0};
        vecs[2] = '{0,   7'd0,   1'b0};
        vecs[3] = '{1,   7'd1,   1'b0};
        vecs[4] = '{64,  7'd64,  1'b0};
        vecs[5] = '{126, 7'd126, 1'b0};
        vecs[6] = '{127, 7'd127, 1'b0};
        vecs[7] = '{128, 7'd127, 1'b1};

        // reset
        reset  = 1'b1;
        start0 = 1'b0;
        start1 = 1'b0;
        pwm0   = 1'b0;
        pwm1   = 1'b0;
        repeat (3) step();
        reset = 1'b0;
        check("rst_rpm0", rpm0, 0);
        check("rst_valid0", valid0, 0);
        check("rst_sat0", sat0, 0);
        check("rst_busy0", busy0, 0);
        check("rst_busy1", busy1, 0);
        check("rst_valid1", valid1, 0);
        step();

        // table-driven generator loop-back windows
        for (int v = 0; v < 8; v++) begin
            for (int k = 0; k < PERIOD; k++) win_bits[k] = (k < vecs[v].hi_len);
            run_window($sformatf("vec%0d", v), vecs[v].exp_rpm, vecs[v].exp_sat);
        end
        // all-low window right after the saturated one clears sat
        for (int k = 0; k < PERIOD; k++) win_bits[k] = 1'b0;
        run_window("after_sat_low", 7'd0, 1'b0);

        // randomized windows against the counting model
        for (int r = 0; r < 6; r++) begin
            int duty;
            duty = $urandom_range(0, 100);
            for (int k = 0; k < PERIOD; k++) win_bits[k] = ($urandom_range(0, 99) < duty);
            if (r == 5) for (int k = 0; k < PERIOD; k++) win_bits[k] = 1'b1;
            cnt = model_count();
            repeat ($urandom_range(0, 5)) begin
                pwm0 = 1'($urandom_range(0, 1));
                step();
            end
            run_window($sformatf("rand%0d", r), (cnt >= PERIOD) ? 7'd127 : 7'(cnt), (cnt == PERIOD));
        end

        // start coincident with DONE: strobe fires and next window has no gap
        start0 = 1'b1;
        step();
        start0 = 1'b0;
        for (int k = 0; k < PERIOD; k++) begin
            pwm0 = (k < 20);
            step();
        end
        start0 = 1'b1;
        pwm0   = 1'b0;
        step();
        start0 = 1'b0;
        check("chain_valid_a", valid0, 1);
        check("chain_rpm_a", rpm0, 20);
        check("chain_busy", busy0, 1);
        for (int k = 0; k < PERIOD; k++) begin
            pwm0 = 1'b1;
            step();
        end
        step();
        check("chain_valid_b", valid0, 1);
        check("chain_rpm_b", rpm0, 127);
        check("chain_sat_b", sat0, 1);

        // restart 60 cycles into a window
        step();
        strobes = 0;
        pwm0    = 1'b1;
        start0  = 1'b1;
        step();
        start0 = 1'b0;
        for (int k = 1; k < 60; k++) begin
            step();
            if (valid0) strobes++;
        end
        start0 = 1'b1;
        step();
        start0 = 1'b0;
        for (int k = 0; k < PERIOD; k++) begin
            step();
            if (valid0) strobes++;
        end
        check("restart_no_old_strobe", strobes, 0);
        step();
        check("restart_valid", valid0, 1);
        check("restart_rpm", rpm0, 127);
        check("restart_sat", sat0, 1);

        // reset mid-window
        step();
        pwm0   = 1'b1;
        start0 = 1'b1;
        step();
        start0 = 1'b0;
        repeat (50) step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("midrst_busy", busy0, 0);
        check("midrst_rpm", rpm0, 0);
        check("midrst_sat", sat0, 0);
        check("midrst_valid", valid0, 0);
        strobes = 0;
        for (int k = 0; k < 200; k++) begin
            pwm0 = 1'($urandom_range(0, 1));
            step();
            if (valid0) strobes++;
        end
        check("midrst_no_strobe", strobes, 0);
        for (int k = 0; k < PERIOD; k++) win_bits[k] = (k < 90);
        run_window("post_rst", 7'd90, 1'b0);

        // continuous mode with 2 sync stages on dut1
        start1 = 1'b1;
        step();
        start1 = 1'b0;
        n_str1 = 0;
        last_n = 0;
        for (int n = 0; n < 129 * 6 + 10; n++) begin
            step();
            if (valid1) begin
                n_str1++;
                check($sformatf("cont_busy_%0d", n_str1), busy1, 1);
                if (n_str1 > 1) begin
                    check($sformatf("cont_gap_%0d", n_str1), n - last_n, 129);
                    check($sformatf("cont_rpm_%0d", n_str1), rpm1, 100);
                    check($sformatf("cont_sat_%0d", n_str1), sat1, 0);
                end
                last_n = n;
            end
        end
        check("cont_strobe_count", n_str1, 6);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
